// File: rtl/cont_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cont_sweep_ctrl
//  Description : Sweep sequencer around a W-bit up/down counter. Runs a
//                programmed number of sweeps between stored bounds in
//                up-wrap, down-wrap or bounce mode, then pulses done.
//                Configured over a valid/ready port while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cont_sweep_ctrl #(
    parameter int W        = 4,
    parameter int SWEEPS_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [W-1:0]        cfg_lo,
    input  logic [W-1:0]        cfg_hi,
    input  logic [SWEEPS_W-1:0] cfg_sweeps,
    input  logic [1:0]          cfg_mode,
    input  logic                start,
    input  logic                pause,
    input  logic                abort,
    output logic [W-1:0]        s,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic [SWEEPS_W-1:0] sweep_cnt,
    output logic                err
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;
    localparam logic [1:0] c_MODE_DOWN = 2'b01;
    localparam logic [1:0] c_MODE_BNC  = 2'b10;

    logic [1:0]          r_state;
    logic [W-1:0]        r_lo;
    logic [W-1:0]        r_hi;
    logic [SWEEPS_W-1:0] r_sweeps;
    logic [1:0]          r_mode;
    logic [W-1:0]        r_s;
    logic                r_dir;
    logic                r_busy;
    logic                r_done;
    logic [SWEEPS_W-1:0] r_cnt;
    logic                r_err;

    logic                w_cfg_hs;
    logic                w_at_end;
    logic [SWEEPS_W:0]   w_cnt_inc;
    logic                w_last;
    logic [SWEEPS_W-1:0] w_cnt_sat;

    assign cfg_ready = (r_state == c_ST_IDLE);
    assign w_cfg_hs  = cfg_valid && cfg_ready;

    // The extra MSB of the increment doubles as the saturation flag and keeps
    // the final-sweep compare free of wrap-around aliasing.
    assign w_cnt_inc = {1'b0, r_cnt} + {{SWEEPS_W{1'b0}}, 1'b1};
    assign w_cnt_sat = w_cnt_inc[SWEEPS_W] ? r_cnt : w_cnt_inc[SWEEPS_W-1:0];
    assign w_last    = (r_sweeps != '0) && (w_cnt_inc == {1'b0, r_sweeps});
    assign w_at_end  = r_dir ? (r_s == r_lo) : (r_s == r_hi);

    assign s         = r_s;
    assign dir       = r_dir;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sweep_cnt = r_cnt;
    assign err       = r_err;

    // Sequencer FSM: config capture, run stepping and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_lo     <= '0;
            r_hi     <= '1;
            r_sweeps <= '0;
            r_mode   <= c_MODE_BNC;
            r_s      <= '0;
            r_dir    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_cfg_hs) begin
                        // A degenerate or inverted range is refused so a run
                        // can never step outside [lo,hi].
                        if (cfg_lo < cfg_hi) begin
                            r_lo     <= cfg_lo;
                            r_hi     <= cfg_hi;
                            r_sweeps <= cfg_sweeps;
                            r_mode   <= cfg_mode;
                            r_err    <= 1'b0;
                        end else begin
                            r_err    <= 1'b1;
                        end
                    end else if (start) begin
                        r_state <= c_ST_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        if (r_mode == c_MODE_DOWN) begin
                            r_s   <= r_hi;
                            r_dir <= 1'b1;
                        end else begin
                            r_s   <= r_lo;
                            r_dir <= 1'b0;
                        end
                    end
                end

                c_ST_RUN: begin
                    if (abort) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!pause) begin
                        if (!w_at_end) begin
                            r_s <= r_dir ? (r_s - W'(1)) : (r_s + W'(1));
                        end else if (w_last) begin
                            r_cnt   <= w_cnt_inc[SWEEPS_W-1:0];
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_sat;
                            if (r_mode[1]) begin
                                r_dir <= ~r_dir;
                                r_s   <= r_dir ? (r_lo + W'(1)) : (r_hi - W'(1));
                            end else if (r_mode == c_MODE_DOWN) begin
                                r_s <= r_hi;
                            end else begin
                                r_s <= r_lo;
                            end
                        end
                    end
                end

                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cont_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cont_sweep_ctrl
//  Description : Scoreboard bench for cont_sweep_ctrl. A driver applies
//                directed and random stimulus and pushes the expected outputs
//                of each edge into a queue; a monitor pops and compares on the
//                falling edge. Expected run trajectories are generated as
//                whole sweep lists from the bounds, mode and sweep count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cont_sweep_ctrl;

    localparam int W  = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  cfg_lo;
    logic [W-1:0]  cfg_hi;
    logic [SW-1:0] cfg_sweeps;
    logic [1:0]    cfg_mode;
    logic          start;
    logic          pause;
    logic          abort;
    logic [W-1:0]  s;
    logic          dir;
    logic          busy;
    logic          done;
    logic [SW-1:0] sweep_cnt;
    logic          err;

    always #5 clk = ~clk;

    cont_sweep_ctrl #(.W(W), .SWEEPS_W(SW)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_sweeps(cfg_sweeps),
        .cfg_mode(cfg_mode), .start(start), .pause(pause), .abort(abort),
        .s(s), .dir(dir), .busy(busy), .done(done), .sweep_cnt(sweep_cnt),
        .err(err)
    );

    typedef struct {
        int s;
        int dir;
        int cnt;
        bit done;
    } step_t;

    typedef struct {
        int s;
        int dir;
        int busy;
        int done;
        int cnt;
        int err;
        int rdy;
    } exp_t;

    step_t seq[$];
    exp_t  exp_q[$];
    exp_t  e;
    int    checks = 0;
    int    errors = 0;
    int    m_lo, m_hi, m_sw, m_mode;
    int    m_phase;   // 0 idle, 1 running, 2 completion cycle

    function automatic void push_step(int v, int d, int c);
        step_t t;
        t.s = v; t.dir = d; t.cnt = c; t.done = 1'b0;
        seq.push_back(t);
    endfunction

    // Whole-run trajectory: every value s takes, sweep by sweep.
    function automatic void build_seq();
        int    k;
        int    ks;
        step_t t;
        seq.delete();
        k = 0;
        while (1) begin
            ks = (k > 15) ? 15 : k;
            if (m_mode == 0) begin
                for (int v = m_lo; v <= m_hi; v++) push_step(v, 0, ks);
            end else if (m_mode == 1) begin
                for (int v = m_hi; v >= m_lo; v--) push_step(v, 1, ks);
            end else if (k == 0) begin
                for (int v = m_lo; v <= m_hi; v++) push_step(v, 0, 0);
            end else if (k % 2 == 1) begin
                for (int v = m_hi - 1; v >= m_lo; v--) push_step(v, 1, ks);
            end else begin
                for (int v = m_lo + 1; v <= m_hi; v++) push_step(v, 0, ks);
            end
            if (m_sw != 0 && k + 1 == m_sw) begin
                t = seq[$];
                t.cnt = k + 1;
                t.done = 1'b1;
                seq.push_back(t);
                break;
            end
            k++;
            if (seq.size() > 1500) break;
        end
    endfunction

    // Expected outputs after the edge that just sampled the current inputs
    function automatic void model();
        step_t t;
        if (rst) begin
            m_lo = 0; m_hi = 15; m_sw = 0; m_mode = 2; m_phase = 0;
            e.s = 0; e.dir = 0; e.busy = 0; e.done = 0; e.cnt = 0; e.err = 0;
        end else begin
            case (m_phase)
                0: begin
                    e.done = 0;
                    if (cfg_valid) begin
                        if (cfg_lo < cfg_hi) begin
                            m_lo   = int'(cfg_lo);
                            m_hi   = int'(cfg_hi);
                            m_sw   = int'(cfg_sweeps);
                            m_mode = (cfg_mode >= 2'd2) ? 2 : int'(cfg_mode);
                            e.err  = 0;
                        end else begin
                            e.err = 1;
                        end
                    end else if (start) begin
                        build_seq();
                        t = seq.pop_front();
                        e.s = t.s; e.dir = t.dir; e.cnt = t.cnt; e.busy = 1;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (abort) begin
                        e.busy = 0;
                        m_phase = 0;
                    end else if (!pause && seq.size() > 0) begin
                        t = seq.pop_front();
                        e.s = t.s; e.dir = t.dir; e.cnt = t.cnt;
                        if (t.done) begin
                            e.done = 1; e.busy = 0; m_phase = 2;
                        end
                    end
                end
                default: begin
                    e.done = 0;
                    m_phase = 0;
                end
            endcase
        end
        e.rdy = (m_phase == 0) ? 1 : 0;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare every registered output once per cycle
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("s",         32'(s),         x.s);
                chk("dir",       32'(dir),       x.dir);
                chk("busy",      32'(busy),      x.busy);
                chk("done",      32'(done),      x.done);
                chk("sweep_cnt", 32'(sweep_cnt), x.cnt);
                chk("err",       32'(err),       x.err);
                chk("cfg_ready", 32'(cfg_ready), x.rdy);
            end
        end
    end

    task automatic step(input bit r, input bit cv, input int lo, input int hi,
                        input int sw, input int md, input bit st, input bit pa,
                        input bit ab);
        rst        = r;
        cfg_valid  = cv;
        cfg_lo     = W'(lo);
        cfg_hi     = W'(hi);
        cfg_sweeps = SW'(sw);
        cfg_mode   = 2'(md);
        start      = st;
        pause      = pa;
        abort      = ab;
        @(posedge clk);
        #1;
        model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int lo, input int hi, input int sw, input int md);
        step(0, 1, lo, hi, sw, md, 0, 0, 0);
    endtask

    task automatic go();
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Default config: bounce 0..15 forever, then abort
        go();
        idle(40);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Up-wrap 2..5, two sweeps
        cfg(2, 5, 2, 0);
        go();
        idle(12);

        // Bounce 2..5, two sweeps
        cfg(2, 5, 2, 2);
        go();
        idle(10);

        // Rejected config keeps previous, then down-wrap 1..3
        cfg(7, 7, 1, 0);
        go();
        idle(10);
        cfg(1, 3, 3, 1);
        go();
        idle(14);

        // Pause and abort during an endless up-wrap run
        cfg(0, 9, 0, 0);
        go();
        idle(4);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Reset mid-run, then config and start together
        go();
        idle(9);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 6, 1, 0, 1, 0, 0);
        idle(3);
        go();
        idle(6);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 150) == 0,
                 ($urandom % 8) == 0,
                 $urandom_range(0, 15),
                 $urandom_range(0, 15),
                 $urandom_range(0, 4),
                 $urandom_range(0, 3),
                 ($urandom % 4) == 0,
                 ($urandom % 5) == 0,
                 ($urandom % 40) == 0);
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
